// File: rtl/axi4_burst_master.sv
// axi4_burst_master
//
// Single-outstanding AXI4 burst initiator. A command (write or read, start
// address, beats-minus-one) is accepted in IDLE. The block then runs one INCR
// burst of 32-bit beats on the AXI4 channels and returns to IDLE via a
// one-cycle done pulse that carries the final response code.
//
// Handshake rule used on every channel and stream in this file: a transfer
// happens on a rising clk edge where VALID and READY are both 1. A VALID
// raised by this block stays high, with its payload stable, until that edge.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len  burst direction, start address, beats-1
//   wr_data/wr_strb/wr_valid/wr_ready   write-beat source stream
//   rd_data/rd_last/rd_valid/rd_ready   read-beat sink stream
//   done, done_resp               completion pulse and final response
//   M_AXI4_AW*/W*/B*/AR*/R*       AXI4 initiator ports
//   dbg_state_o                   current FSM state for observation
//
// Build option
//   AXI4_MASTER_4K_CHECK_EN : when defined, a command whose burst would cross
//   a 4 KB boundary is not issued; it completes at once with done_resp=2'b10.
module axi4_burst_master #(
  parameter int AXI4_ID_WIDTH = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TXN_ID        = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH/8-1:0]  wr_strb,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     done,
  output logic [1:0]               done_resp,
  output logic [AXI4_ID_WIDTH-1:0] M_AXI4_AWID,
  output logic [ADDR_WIDTH-1:0]    M_AXI4_AWADDR,
  output logic [7:0]               M_AXI4_AWLEN,
  output logic [2:0]               M_AXI4_AWSIZE,
  output logic [1:0]               M_AXI4_AWBURST,
  output logic                     M_AXI4_AWVALID,
  input  logic                     M_AXI4_AWREADY,
  output logic [DATA_WIDTH-1:0]    M_AXI4_WDATA,
  output logic [DATA_WIDTH/8-1:0]  M_AXI4_WSTRB,
  output logic                     M_AXI4_WLAST,
  output logic                     M_AXI4_WVALID,
  input  logic                     M_AXI4_WREADY,
  input  logic [AXI4_ID_WIDTH-1:0] M_AXI4_BID,
  input  logic [1:0]               M_AXI4_BRESP,
  input  logic                     M_AXI4_BVALID,
  output logic                     M_AXI4_BREADY,
  output logic [AXI4_ID_WIDTH-1:0] M_AXI4_ARID,
  output logic [ADDR_WIDTH-1:0]    M_AXI4_ARADDR,
  output logic [7:0]               M_AXI4_ARLEN,
  output logic [2:0]               M_AXI4_ARSIZE,
  output logic [1:0]               M_AXI4_ARBURST,
  output logic                     M_AXI4_ARVALID,
  input  logic                     M_AXI4_ARREADY,
  input  logic [AXI4_ID_WIDTH-1:0] M_AXI4_RID,
  input  logic [DATA_WIDTH-1:0]    M_AXI4_RDATA,
  input  logic [1:0]               M_AXI4_RRESP,
  input  logic                     M_AXI4_RLAST,
  input  logic                     M_AXI4_RVALID,
  output logic                     M_AXI4_RREADY,
  output logic [2:0]               dbg_state_o
);

  localparam logic [AXI4_ID_WIDTH-1:0] ID_L = AXI4_ID_WIDTH'(TXN_ID);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              resp_q, resp_d;
  logic                    cross_4k;
  logic                    beat_last;
  logic [1:0]              r_resp_max;

  // Burst byte span check: addr[11:0] + (len+1)*4 > 4096. 14 bits hold the
  // largest sum (4095 + 1024).
`ifdef AXI4_MASTER_4K_CHECK_EN
  logic [13:0] span_end;
  assign span_end = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign cross_4k = (span_end > 14'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  assign beat_last  = (cnt_q == len_q);
  assign r_resp_max = (M_AXI4_RRESP > resp_q) ? M_AXI4_RRESP : resp_q;

  // Payload fields come straight from the latched command, so they are stable
  // for as long as the corresponding VALID is held.
  assign M_AXI4_AWID    = ID_L;
  assign M_AXI4_AWADDR  = addr_q;
  assign M_AXI4_AWLEN   = len_q;
  assign M_AXI4_AWSIZE  = 3'b010;
  assign M_AXI4_AWBURST = 2'b01;
  assign M_AXI4_ARID    = ID_L;
  assign M_AXI4_ARADDR  = addr_q;
  assign M_AXI4_ARLEN   = len_q;
  assign M_AXI4_ARSIZE  = 3'b010;
  assign M_AXI4_ARBURST = 2'b01;
  assign M_AXI4_WDATA   = wr_data;
  assign M_AXI4_WSTRB   = wr_strb;
  assign rd_data        = M_AXI4_RDATA;
  assign rd_last        = M_AXI4_RLAST;
  assign done_resp      = resp_q;
  assign dbg_state_o    = state_q;

  // Gated by rst_n so nothing looks ready while reset is held; the first
  // cycle after release presents ready at once.
  assign cmd_ready = (state_q == S_IDLE) && rst_n;

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    addr_d         = addr_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    resp_d         = resp_q;
    M_AXI4_AWVALID = 1'b0;
    M_AXI4_WVALID  = 1'b0;
    M_AXI4_WLAST   = 1'b0;
    M_AXI4_BREADY  = 1'b0;
    M_AXI4_ARVALID = 1'b0;
    M_AXI4_RREADY  = 1'b0;
    wr_ready       = 1'b0;
    rd_valid       = 1'b0;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          resp_d  = 2'b00;
          if (cross_4k) begin
            resp_d  = 2'b10;
            state_d = S_DONE;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        M_AXI4_AWVALID = 1'b1;
        if (M_AXI4_AWREADY) state_d = S_W;
      end
      S_W: begin
        M_AXI4_WVALID = wr_valid;
        wr_ready      = M_AXI4_WREADY;
        M_AXI4_WLAST  = beat_last;
        if (wr_valid && M_AXI4_WREADY) begin
          cnt_d = cnt_q + 8'd1;
          if (beat_last) state_d = S_B;
        end
      end
      S_B: begin
        M_AXI4_BREADY = 1'b1;
        if (M_AXI4_BVALID) begin
          resp_d  = (M_AXI4_BID != ID_L) ? 2'b10 : M_AXI4_BRESP;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        M_AXI4_ARVALID = 1'b1;
        if (M_AXI4_ARREADY) state_d = S_R;
      end
      S_R: begin
        rd_valid      = M_AXI4_RVALID;
        M_AXI4_RREADY = rd_ready;
        if (M_AXI4_RVALID && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          // RLAST must coincide exactly with beat len; any disagreement is a
          // slave protocol error reported as SLVERR.
          resp_d = (M_AXI4_RLAST != beat_last) ? 2'b10 : r_resp_max;
          if (beat_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Direction is implied by the state path; RID is not checked on reads.
  logic unused_ok;
  assign unused_ok = ^{write_q, M_AXI4_RID};

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 Parameters SHALL be: AXI4_ID_WIDTH, 4, ID width; ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; TXN_ID, 0, ID driven on AWID/ARID.
REQ-002 clk  in  1  clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_write  in  1  1=write burst, 0=read burst.
REQ-006 cmd_addr  in  ADDR_WIDTH  start byte address, word aligned.
REQ-007 cmd_len  in  8  beats minus one.
REQ-008 wr_data/wr_strb/wr_valid/wr_ready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write-beat source stream.
REQ-009 rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA_WIDTH/1/1/1  read-beat sink stream.
REQ-010 done/done_resp  out/out  1/2  one-cycle completion pulse; final response code.
REQ-011 M_AXI4_AW{ID,ADDR,LEN,SIZE,BURST,VALID}/AWREADY, W{DATA,STRB,LAST,VALID}/WREADY, B{ID,RESP,VALID}/BREADY, AR{ID,ADDR,LEN,SIZE,BURST,VALID}/ARREADY, R{ID,DATA,RESP,LAST,VALID}/RREADY SHALL be the AXI4 initiator ports, standard widths and directions.

Function
REQ-012 States SHALL be IDLE, AW, W, B, AR, R, DONE; one transaction outstanding at a time.
REQ-013 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready latches cmd_write/addr/len, resets beat counter, goes to AW (write) or AR (read).
REQ-014 AW: AWVALID=1 with AWID=TXN_ID, AWADDR=latched addr, AWLEN=latched len, AWSIZE=3'b010, AWBURST=2'b01; held stable until AWREADY, then go to W.
REQ-015 W: WVALID=wr_valid, wr_ready=WREADY (combinational, W state only); WDATA/WSTRB=wr_data/wr_strb; WLAST=1 iff beat counter==len; counter increments per WVALID&WREADY; handshake with WLAST goes to B.
REQ-016 W data SHALL NOT be issued before the AW handshake completes.
REQ-017 B: BREADY=1; on BVALID latch BRESP into done_resp, go to DONE; BID mismatch to TXN_ID forces done_resp=2'b10.
REQ-018 AR: ARVALID=1 with fields as REQ-014 on AR channel; held until ARREADY, then go to R.
REQ-019 R: rd_valid=RVALID, RREADY=rd_ready (combinational, R state only); rd_data=RDATA, rd_last=RLAST; done_resp accumulates the maximum RRESP over the burst.
REQ-020 R: RLAST on a beat other than beat len, or no RLAST at beat len, SHALL force done_resp=2'b10; R handshake on beat len goes to DONE regardless of RLAST.
REQ-021 DONE: done=1 for exactly one cycle, next state IDLE; earliest next cmd_ready one cycle after done.
REQ-022 All AXI VALID outputs SHALL be 0 outside their own state; no VALID deasserted before its READY.
REQ-023 Beat counter SHALL be 8 bits; len=255 yields 256 beats without wrap error.

Reset
REQ-024 On rst_n low: state=IDLE, all VALID/READY outputs and done=0, done_resp=2'b00, counters=0, latched command=0.
REQ-025 Reset mid-burst SHALL abort immediately with no done pulse; first post-reset cycle presents cmd_ready=1.

Configuration
REQ-026 Macro AXI4_MASTER_4K_CHECK_EN: when defined, a command whose burst spans a 4 KB boundary (addr[11:0] + (len+1)*4 > 4096) SHALL skip AW/AR/W/R, go to DONE and pulse done with done_resp=2'b10; when undefined, no check, all commands issued as received.

Verification
REQ-027 Write addr=0x100, len=3, AWREADY delayed 2 cycles, wr_valid always 1 -> AWLEN=3, 4 W beats, WLAST on 4th only, BRESP=00 -> done pulse, done_resp=00.
REQ-028 Read addr=0x200, len=7, rd_ready toggling every cycle -> 8 R beats forwarded in order, RREADY follows rd_ready, done_resp=00 after 8th beat.
REQ-029 Read len=1, slave returns RRESP=10 on beat 0, 00 on beat 1 -> done_resp=10.
REQ-030 Read len=3, slave asserts RLAST on beat 1 -> done_resp=10, done after beat 3.
REQ-031 With AXI4_MASTER_4K_CHECK_EN: write addr=0xFF8, len=3 -> no AWVALID, done pulse with done_resp=10; without macro, AWVALID with AWADDR=0xFF8.
REQ-032 Assert rst_n low during W beat 2 of len=7 write -> WVALID/AWVALID=0 immediately, no done, cmd_ready=1 after release.
